// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver with a show-ahead byte FIFO. It also reports framing errors,
// overflow and end-of-line events as single-cycle pulses.
module uart_rx_monitor #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          rxd_i,
  input  logic                          rd_i,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          frame_err_o,
  output logic                          overflow_o,
  output logic                          line_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sr_q, sr_d;
  logic          rx_meta, rxs;
  logic          push, ferr;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd_i;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
    idx_d   = idx_q;
    sr_d    = sr_q;
    push    = 1'b0;
    ferr    = 1'b0;
    case (state_q)
      IDLE: if (!rxs) begin
        state_d = START;
        cnt_d   = CNT_HALF;
      end
      START: if (cnt_q == '0) begin
        if (!rxs) begin
          state_d = DATA;
          cnt_d   = CNT_FULL;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: if (cnt_q == '0) begin
        sr_d[idx_q] = rxs;
        cnt_d       = CNT_FULL;
        if (idx_q == 3'd7) state_d = STOP;
        else               idx_d   = idx_q + 3'd1;
      end
      STOP: if (cnt_q == '0) begin
        if (rxs) begin
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          ferr    = 1'b1;
          state_d = WAIT_HIGH;
        end
      end
      WAIT_HIGH: if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_q;
  logic          full, pop, wr_en;

  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign valid_o = (count_q != '0);
  assign pop     = rd_i && valid_o;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign wr_en   = push && (!full || pop);
  assign count_o = count_q;
  assign data_o  = valid_o ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= sr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
      line_o      <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      frame_err_o <= ferr;
      overflow_o  <= push && full && !pop;
      line_o      <= wr_en && (sr_q == 8'h0A);
    end
  end

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor: frames are driven on negedges, outputs sampled on negedges.
module tb_uart_rx_monitor;
  localparam int CPB   = 40;
  localparam int DEPTH = 16;
  // Negedges from frame start until the one just after the stop-sample posedge.
  localparam int STOP_NEG = 3 + CPB/2 + 9*CPB;

  logic       clk_i = 1'b0;
  logic       rst_ni, rxd_i, rd_i;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, overflow_o, line_o;
  logic [$clog2(DEPTH):0] count_o;

  int n_chk = 0, n_err = 0;
  int n_ferr = 0, n_ovf = 0, n_line = 0;
  int snap;

  uart_rx_monitor #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rxd_i(rxd_i), .rd_i(rd_i),
    .data_o(data_o), .valid_o(valid_o), .count_o(count_o),
    .frame_err_o(frame_err_o), .overflow_o(overflow_o), .line_o(line_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (frame_err_o) n_ferr++;
    if (overflow_o)  n_ovf++;
    if (line_o)      n_line++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Caller must be at a negedge; returns at a negedge with the line idle high.
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rxd_i = 1'b0;
    repeat (CPB) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rxd_i = b[i];
      repeat (CPB) @(negedge clk_i);
    end
    rxd_i = stop;
    repeat (CPB) @(negedge clk_i);
    rxd_i = 1'b1;
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    check(tag, {24'h0, data_o}, {24'h0, exp});
    rd_i = 1'b1;
    @(negedge clk_i);
    rd_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni = 1'b0; rxd_i = 1'b1; rd_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_count", count_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_data",  data_o, 0);
    check("rst_pulses", {frame_err_o, overflow_o, line_o}, 0);
    rst_ni = 1'b1;
    repeat (1000) @(negedge clk_i);
    check("idle_count", count_o, 0);
    check("idle_valid", valid_o, 0);
    check("idle_pulses", n_ferr + n_ovf + n_line, 0);

    // rd_i on an empty FIFO must not underflow
    rd_i = 1'b1; @(negedge clk_i); rd_i = 1'b0;
    check("empty_pop_count", count_o, 0);

    // 0x55 then 0xA3 back-to-back, with push latency checked on the first
    fork
      send_byte(8'h55);
      begin
        repeat (STOP_NEG - 1) @(negedge clk_i);
        check("lat_valid_before", valid_o, 0);
        @(negedge clk_i);
        check("lat_valid_after", valid_o, 1);
        check("lat_data", data_o, 8'h55);
      end
    join
    send_byte(8'hA3);
    check("b2b_count", count_o, 2);
    pop("b2b_pop0", 8'h55);
    pop("b2b_pop1", 8'hA3);
    check("b2b_empty", valid_o, 0);

    // short low glitch is rejected
    rxd_i = 1'b0; repeat (CPB/4) @(negedge clk_i);
    rxd_i = 1'b1; repeat (2*CPB) @(negedge clk_i);
    check("glitch_count", count_o, 0);
    check("glitch_ferr", n_ferr, 0);

    // framing error, break, then a good byte
    snap = n_ferr;
    fork
      send_byte(8'h41, 1'b0);
      begin
        repeat (STOP_NEG - 1) @(negedge clk_i);
        check("ferr_before", frame_err_o, 0);
        @(negedge clk_i);
        check("ferr_pulse", frame_err_o, 1);
        @(negedge clk_i);
        check("ferr_after", frame_err_o, 0);
      end
    join
    rxd_i = 1'b0; repeat (2*CPB) @(negedge clk_i);
    rxd_i = 1'b1; repeat (CPB) @(negedge clk_i);
    send_byte(8'h42);
    check("ferr_once", n_ferr - snap, 1);
    check("ferr_count", count_o, 1);
    pop("ferr_pop", 8'h42);

    // fill to 16, 17th byte overflows
    snap = n_ovf;
    for (int i = 0; i < DEPTH; i++) send_byte(8'(i));
    check("full_count", count_o, DEPTH);
    fork
      send_byte(8'h10);
      begin
        repeat (STOP_NEG) @(negedge clk_i);
        check("ovf_pulse", overflow_o, 1);
      end
    join
    check("ovf_once", n_ovf - snap, 1);
    check("ovf_count", count_o, DEPTH);
    for (int i = 0; i < DEPTH; i++) pop($sformatf("ovf_pop%0d", i), 8'(i));
    check("ovf_drained", valid_o, 0);
    for (int i = 0; i < 4; i++) send_byte(8'h20 + 8'(i));
    check("wrap_count", count_o, 4);
    for (int i = 0; i < 4; i++) pop($sformatf("wrap_pop%0d", i), 8'h20 + 8'(i));

    // "OK\n" with line pulse timing
    snap = n_line;
    send_byte(8'h4F);
    send_byte(8'h4B);
    fork
      send_byte(8'h0A);
      begin
        repeat (STOP_NEG - 1) @(negedge clk_i);
        check("line_before", line_o, 0);
        @(negedge clk_i);
        check("line_pulse", line_o, 1);
        @(negedge clk_i);
        check("line_after", line_o, 0);
      end
    join
    check("line_once", n_line - snap, 1);
    check("ok_count", count_o, 3);

    // asynchronous reset in the middle of a fourth frame
    rxd_i = 1'b0; repeat (3*CPB) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_count", count_o, 0);
    check("arst_valid", valid_o, 0);
    check("arst_data", data_o, 0);
    @(negedge clk_i);
    rxd_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (CPB) @(negedge clk_i);
    check("post_rst_count", count_o, 0);
    send_byte(8'h31);
    check("post_rst_count1", count_o, 1);
    pop("post_rst_pop", 8'h31);
    check("post_rst_empty", valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
